// File: rtl/prach_pkg.sv
// Shared defaults and types for the PRACH reshape block.
//   - default lane count, sample width, block size and channel count
//   - sample_t: one complex sample {dr, di} at the default width
//   - idx_w(): index width for an array of n entries (at least 1 bit)
package prach_pkg;

  localparam int unsigned PRACH_NUM_ANT = 3;
  localparam int unsigned PRACH_DATA_W  = 16;
  localparam int unsigned PRACH_SIZE    = 8;
  localparam int unsigned PRACH_NUM_CHN = 8;
  localparam int unsigned CHN_TAG_W     = 8;

  typedef struct packed {
    logic [PRACH_DATA_W-1:0] dr;
    logic [PRACH_DATA_W-1:0] di;
  } sample_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prach_reshape_ctrl.sv
// Per-channel write pointer, ping-pong bank bit and primed flag.
//   clk, rst   : clock, asynchronous active-high reset
//   clr_i      : clear every channel's pointer/bank/primed this cycle
//   wr_en_i    : accepted beat for channel chn_i (advances its pointer)
//   chn_i      : channel of the current beat
//   wcnt_o     : write index seen by the current beat (post-clear)
//   bank_o     : write bank seen by the current beat (post-clear)
//   primed_o   : channel has a complete block in the other bank
module prach_reshape_ctrl
  import prach_pkg::*;
#(
  parameter int unsigned SIZE    = PRACH_SIZE,
  parameter int unsigned NUM_CHN = PRACH_NUM_CHN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic                        wr_en_i,
  input  logic [idx_w(NUM_CHN)-1:0]   chn_i,
  output logic [$clog2(SIZE)-1:0]     wcnt_o,
  output logic                        bank_o,
  output logic                        primed_o
);

  localparam int unsigned CNT_W = $clog2(SIZE);

  logic [CNT_W-1:0]   wcnt_q [NUM_CHN];
  logic [CNT_W-1:0]   wcnt_d [NUM_CHN];
  logic [NUM_CHN-1:0] bank_q, bank_d;
  logic [NUM_CHN-1:0] primed_q, primed_d;

  // A clear in the same cycle as a beat makes that beat the first after the clear.
  always_comb begin
    wcnt_o   = clr_i ? '0   : wcnt_q[chn_i];
    bank_o   = clr_i ? 1'b0 : bank_q[chn_i];
    primed_o = clr_i ? 1'b0 : primed_q[chn_i];
  end

  always_comb begin
    for (int c = 0; c < NUM_CHN; c++) begin
      wcnt_d[c] = clr_i ? '0 : wcnt_q[c];
    end
    bank_d   = clr_i ? '0 : bank_q;
    primed_d = clr_i ? '0 : primed_q;
    if (wr_en_i) begin
      wcnt_d[chn_i] = wcnt_o + CNT_W'(1);
      if (wcnt_o == CNT_W'(SIZE - 1)) begin
        bank_d[chn_i]   = ~bank_o;
        primed_d[chn_i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CHN; c++) begin
        wcnt_q[c] <= '0;
      end
      bank_q   <= '0;
      primed_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CHN; c++) begin
        wcnt_q[c] <= wcnt_d[c];
      end
      bank_q   <= bank_d;
      primed_q <= primed_d;
    end
  end

endmodule

// File: rtl/prach_reshape_n.sv
// PRACH reshape: per-channel ping-pong buffering of complex samples, re-emitted
// as pairs of real parts (first half of a block) then pairs of imaginary parts
// (second half), one block behind the input. Two-cycle latency in all modes.
//   clk, rst           : clock, asynchronous active-high reset
//   din_dr / din_di    : per-antenna real / imaginary input components
//   din_dv, din_chn    : input beat valid and channel tag
//   sync_in            : frame sync, clears all channel pointers
//   bypass             : 1 = pass dr/di straight to dp1/dp2
//   dout_dp1 / dout_dp2: per-antenna output lanes
//   dout_dv, dout_chn  : output beat valid and channel tag (held when idle)
//   sync_out           : sync_in delayed by two cycles
module prach_reshape_n
  import prach_pkg::*;
#(
  parameter int unsigned NUM_ANT = PRACH_NUM_ANT,
  parameter int unsigned DATA_W  = PRACH_DATA_W,
  parameter int unsigned SIZE    = PRACH_SIZE,
  parameter int unsigned NUM_CHN = PRACH_NUM_CHN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_ANT*DATA_W-1:0] din_dr,
  input  logic [NUM_ANT*DATA_W-1:0] din_di,
  input  logic                      din_dv,
  input  logic [CHN_TAG_W-1:0]      din_chn,
  input  logic                      sync_in,
  input  logic                      bypass,
  output logic [NUM_ANT*DATA_W-1:0] dout_dp1,
  output logic [NUM_ANT*DATA_W-1:0] dout_dp2,
  output logic                      dout_dv,
  output logic [CHN_TAG_W-1:0]      dout_chn,
  output logic                      sync_out
);

  localparam int unsigned AW    = NUM_ANT * DATA_W;
  localparam int unsigned CNT_W = $clog2(SIZE);
  localparam int unsigned CHN_W = idx_w(NUM_CHN);

  typedef struct packed {
    logic [DATA_W-1:0] dr;
    logic [DATA_W-1:0] di;
  } smp_t;

  // Storage is not reset; the primed flags guard against reading stale banks.
  smp_t mem_q [NUM_CHN][2][SIZE][NUM_ANT];

  logic             bypass_q, bypass_d;
  logic             clr, chn_ok, wr_en;
  logic [CHN_W-1:0] chn_idx;
  logic [CNT_W-1:0] wcnt;
  logic             wr_bank, primed;

  logic [CNT_W:0]   pair_tmp;
  logic [CNT_W-1:0] idx0, idx1;
  logic             hi_half;
  smp_t             c0, c1;
  logic [AW-1:0]    p1_rd, p2_rd;

  logic                 s1_vld_q, s1_vld_d, s1_sync_q, s1_sync_d;
  logic [CHN_TAG_W-1:0] s1_chn_q, s1_chn_d;
  logic [AW-1:0]        s1_p1_q, s1_p1_d, s1_p2_q, s1_p2_d;
  logic                 dv_q, dv_d, sync_q, sync_d;
  logic [CHN_TAG_W-1:0] chn_q, chn_d;
  logic [AW-1:0]        dp1_q, dp1_d, dp2_q, dp2_d;

  // Any bypass edge resets the channel state exactly like a sync pulse.
  always_comb begin
    bypass_d = bypass;
    clr      = sync_in | (bypass ^ bypass_q);
    chn_ok   = 32'(din_chn) < NUM_CHN;
    wr_en    = din_dv & chn_ok & ~bypass;
    chn_idx  = din_chn[CHN_W-1:0];
  end

  prach_reshape_ctrl #(
    .SIZE    (SIZE),
    .NUM_CHN (NUM_CHN)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .wr_en_i  (wr_en),
    .chn_i    (chn_idx),
    .wcnt_o   (wcnt),
    .bank_o   (wr_bank),
    .primed_o (primed)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int a = 0; a < NUM_ANT; a++) begin
        mem_q[chn_idx][wr_bank][wcnt][a] <= {din_dr[a*DATA_W +: DATA_W],
                                             din_di[a*DATA_W +: DATA_W]};
      end
    end
  end

  // Output k reads samples 2k, 2k+1 modulo SIZE (dropping k's MSB gives 2j in
  // the upper half); the MSB of k selects real or imaginary parts. The read is
  // from the bank not being written, so it is taken in the beat's own cycle.
  always_comb begin
    pair_tmp = {wcnt, 1'b0};
    idx0     = pair_tmp[CNT_W-1:0];
    idx1     = idx0 | CNT_W'(1);
    hi_half  = wcnt[CNT_W-1];
    p1_rd    = '0;
    p2_rd    = '0;
    c0       = '0;
    c1       = '0;
    for (int a = 0; a < NUM_ANT; a++) begin
      c0 = mem_q[chn_idx][~wr_bank][idx0][a];
      c1 = mem_q[chn_idx][~wr_bank][idx1][a];
      p1_rd[a*DATA_W +: DATA_W] = hi_half ? c0.di : c0.dr;
      p2_rd[a*DATA_W +: DATA_W] = hi_half ? c1.di : c1.dr;
    end
  end

  always_comb begin
    s1_vld_d  = bypass ? din_dv : (wr_en & primed);
    s1_p1_d   = bypass ? din_dr : p1_rd;
    s1_p2_d   = bypass ? din_di : p2_rd;
    s1_chn_d  = din_chn;
    s1_sync_d = sync_in;
    dv_d      = s1_vld_q;
    sync_d    = s1_sync_q;
    dp1_d     = s1_vld_q ? s1_p1_q  : dp1_q;
    dp2_d     = s1_vld_q ? s1_p2_q  : dp2_q;
    chn_d     = s1_vld_q ? s1_chn_q : chn_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bypass_q  <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_sync_q <= 1'b0;
      s1_chn_q  <= '0;
      s1_p1_q   <= '0;
      s1_p2_q   <= '0;
      dv_q      <= 1'b0;
      sync_q    <= 1'b0;
      chn_q     <= '0;
      dp1_q     <= '0;
      dp2_q     <= '0;
    end else begin
      bypass_q  <= bypass_d;
      s1_vld_q  <= s1_vld_d;
      s1_sync_q <= s1_sync_d;
      s1_chn_q  <= s1_chn_d;
      s1_p1_q   <= s1_p1_d;
      s1_p2_q   <= s1_p2_d;
      dv_q      <= dv_d;
      sync_q    <= sync_d;
      chn_q     <= chn_d;
      dp1_q     <= dp1_d;
      dp2_q     <= dp2_d;
    end
  end

  assign dout_dp1 = dp1_q;
  assign dout_dp2 = dp2_q;
  assign dout_dv  = dv_q;
  assign dout_chn = chn_q;
  assign sync_out = sync_q;

endmodule

// File: tb/tb_prach_reshape_n.sv
module tb_prach_reshape_n;
  import prach_pkg::*;

  localparam int unsigned NUM_ANT = PRACH_NUM_ANT;
  localparam int unsigned DATA_W  = PRACH_DATA_W;
  localparam int unsigned SIZE    = PRACH_SIZE;
  localparam int unsigned NUM_CHN = PRACH_NUM_CHN;
  localparam int unsigned AW      = NUM_ANT * DATA_W;

  logic          clk, rst;
  logic [AW-1:0] din_dr, din_di, dout_dp1, dout_dp2;
  logic          din_dv, sync_in, bypass, dout_dv, sync_out;
  logic [7:0]    din_chn, dout_chn;

  prach_reshape_n dut (
    .clk      (clk),
    .rst      (rst),
    .din_dr   (din_dr),
    .din_di   (din_di),
    .din_dv   (din_dv),
    .din_chn  (din_chn),
    .sync_in  (sync_in),
    .bypass   (bypass),
    .dout_dp1 (dout_dp1),
    .dout_dp2 (dout_dp2),
    .dout_dv  (dout_dv),
    .dout_chn (dout_chn),
    .sync_out (sync_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int dv_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each channel keeps its current partial block and its
  // last complete block; output k of a new block is drawn from the last one.
  typedef struct {
    bit         vld;
    bit         sync;
    logic [7:0] chn;
    logic [AW-1:0] p1;
    logic [AW-1:0] p2;
  } out_t;

  logic [AW-1:0] m_cur_dr [NUM_CHN][SIZE];
  logic [AW-1:0] m_cur_di [NUM_CHN][SIZE];
  logic [AW-1:0] m_prev_dr [NUM_CHN][SIZE];
  logic [AW-1:0] m_prev_di [NUM_CHN][SIZE];
  int            m_cnt [NUM_CHN];
  bit            m_primed [NUM_CHN];
  bit            m_byp;
  out_t          m_s1, m_out;

  task automatic model_clear();
    for (int c = 0; c < NUM_CHN; c++) begin
      m_cnt[c]    = 0;
      m_primed[c] = 1'b0;
    end
  endtask

  task automatic model_reset();
    model_clear();
    m_byp = 1'b0;
    m_s1  = '{vld: 1'b0, sync: 1'b0, chn: 8'd0, p1: '0, p2: '0};
    m_out = m_s1;
  endtask

  task automatic model_beat();
    out_t r;
    int c, k;
    r = '{vld: 1'b0, sync: sync_in, chn: din_chn, p1: '0, p2: '0};
    if (sync_in || (bypass != m_byp)) model_clear();
    m_byp = bypass;
    if (bypass) begin
      r.vld = din_dv;
      r.p1  = din_dr;
      r.p2  = din_di;
    end else if (din_dv && (int'(din_chn) < NUM_CHN)) begin
      c = int'(din_chn);
      k = m_cnt[c];
      if (m_primed[c]) begin
        r.vld = 1'b1;
        if (k < SIZE / 2) begin
          r.p1 = m_prev_dr[c][2*k];
          r.p2 = m_prev_dr[c][2*k+1];
        end else begin
          r.p1 = m_prev_di[c][2*(k-SIZE/2)];
          r.p2 = m_prev_di[c][2*(k-SIZE/2)+1];
        end
      end
      m_cur_dr[c][k] = din_dr;
      m_cur_di[c][k] = din_di;
      m_cnt[c] = k + 1;
      if (m_cnt[c] == SIZE) begin
        for (int i = 0; i < SIZE; i++) begin
          m_prev_dr[c][i] = m_cur_dr[c][i];
          m_prev_di[c][i] = m_cur_di[c][i];
        end
        m_cnt[c]    = 0;
        m_primed[c] = 1'b1;
      end
    end
    m_s1 = r;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare on the
  // falling edge against what the model says should be showing now.
  task automatic step(input bit dv, input logic [7:0] chn, input logic [AW-1:0] dr,
                      input logic [AW-1:0] di, input bit sy);
    din_dv  = dv;
    din_chn = chn;
    din_dr  = dr;
    din_di  = di;
    sync_in = sy;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_out.vld  = m_s1.vld;
      m_out.sync = m_s1.sync;
      if (m_s1.vld) begin
        m_out.p1  = m_s1.p1;
        m_out.p2  = m_s1.p2;
        m_out.chn = m_s1.chn;
      end
      model_beat();
    end
    @(negedge clk);
    check("sb_dv", 64'(dout_dv), 64'(m_out.vld));
    check("sb_sync", 64'(sync_out), 64'(m_out.sync));
    check("sb_chn", 64'(dout_chn), 64'(m_out.chn));
    check("sb_dp1", 64'(dout_dp1), 64'(m_out.p1));
    check("sb_dp2", 64'(dout_dp2), 64'(m_out.p2));
    if (dout_dv === 1'b1) dv_seen++;
  endtask

  function automatic logic [AW-1:0] rnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[AW-1:0];
  endfunction

  // Antenna a carries v + 256*a so lane mix-ups are visible.
  function automatic logic [AW-1:0] rep(input logic [15:0] v);
    logic [AW-1:0] r;
    for (int a = 0; a < NUM_ANT; a++) r[a*DATA_W +: DATA_W] = v + 16'(a * 256);
    return r;
  endfunction

  task automatic beats(input int n, input logic [7:0] chn);
    for (int i = 0; i < n; i++) step(1'b1, chn, rnd(), rnd(), 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, '0, '0, 1'b0);
  endtask

  typedef struct {
    sample_t     in;
    bit          dv;
    logic [15:0] p1;
    logic [15:0] p2;
  } vec_t;

  vec_t tbl [16];
  int   exp_pairs [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 100, 101, 102, 103, 104, 105, 106, 107};
  logic [AW-1:0] k1234, k5678;

  initial begin
    for (int n = 0; n < 16; n++) begin
      tbl[n].in.dr = 16'(n);
      tbl[n].in.di = 16'(100 + n);
      tbl[n].dv    = (n >= 8);
      tbl[n].p1    = (n >= 8) ? 16'(exp_pairs[2*(n-8)]) : 16'd0;
      tbl[n].p2    = (n >= 8) ? 16'(exp_pairs[2*(n-8)+1]) : 16'd0;
    end
    k1234 = {NUM_ANT{16'h1234}};
    k5678 = {NUM_ANT{16'h5678}};

    rst = 1'b1;
    bypass = 1'b0;
    model_reset();
    idle(3);
    check("rst_dv", 64'(dout_dv), 64'd0);
    check("rst_dp1", 64'(dout_dp1), 64'd0);
    rst = 1'b0;

    // Channel 0 ramp: first block silent, second block emits the first reshaped.
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) step(1'b1, 8'd0, rep(tbl[i].in.dr), rep(tbl[i].in.di), 1'b0);
      else idle(1);
      if (i > 0) begin
        check("tbl_dv", 64'(dout_dv), 64'(tbl[i-1].dv));
        if (tbl[i-1].dv) begin
          check("tbl_dp1", 64'(dout_dp1), 64'(rep(tbl[i-1].p1)));
          check("tbl_dp2", 64'(dout_dp2), 64'(rep(tbl[i-1].p2)));
          check("tbl_chn", 64'(dout_chn), 64'd0);
        end
      end
    end

    // Round-robin over all channels, two blocks each.
    step(1'b0, 8'd0, '0, '0, 1'b1);
    dv_seen = 0;
    for (int b = 0; b < 2 * SIZE; b++)
      for (int c = 0; c < NUM_CHN; c++) step(1'b1, 8'(c), rnd(), rnd(), 1'b0);
    idle(2);
    check("rr_count", 64'(dv_seen), 64'(NUM_CHN * SIZE));

    // Bypass pass-through, then leaving bypass drops the primed state.
    bypass = 1'b1;
    step(1'b1, 8'd3, k1234, k5678, 1'b0);
    idle(1);
    check("byp_dv", 64'(dout_dv), 64'd1);
    check("byp_dp1", 64'(dout_dp1), 64'(k1234));
    check("byp_dp2", 64'(dout_dp2), 64'(k5678));
    check("byp_chn", 64'(dout_chn), 64'd3);
    bypass = 1'b0;
    dv_seen = 0;
    beats(SIZE, 8'd3);
    idle(2);
    check("byp_clear", 64'(dv_seen), 64'd0);
    dv_seen = 0;
    beats(SIZE, 8'd3);
    idle(2);
    check("byp_reprime", 64'(dv_seen), 64'(SIZE));

    // Sync arriving with a beat at wcnt=5 of a primed channel.
    step(1'b0, 8'd0, '0, '0, 1'b1);
    beats(SIZE + 5, 8'd2);
    step(1'b1, 8'd2, rep(16'h0aa0), rep(16'h0bb0), 1'b1);
    dv_seen = 0;
    step(1'b1, 8'd2, rnd(), rnd(), 1'b0);
    check("sync_out", 64'(sync_out), 64'd1);
    beats(SIZE - 2, 8'd2);
    idle(1);
    check("sync_quiet", 64'(dv_seen), 64'd0);
    dv_seen = 0;
    step(1'b1, 8'd2, rnd(), rnd(), 1'b0);
    idle(1);
    check("sync_idx0", 64'(dout_dp1), 64'(rep(16'h0aa0)));
    check("sync_after", 64'(dv_seen), 64'd1);

    // Out-of-range tags interleaved with channel 1.
    step(1'b0, 8'd0, '0, '0, 1'b1);
    dv_seen = 0;
    for (int i = 0; i < 2 * SIZE; i++) begin
      step(1'b1, 8'd1, rnd(), rnd(), 1'b0);
      step(1'b1, 8'd200, rnd(), rnd(), 1'b0);
    end
    idle(2);
    check("drop_count", 64'(dv_seen), 64'(SIZE));

    // Asynchronous reset mid-block.
    beats(3, 8'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_dv", 64'(dout_dv), 64'd0);
    check("arst_dp1", 64'(dout_dp1), 64'd0);
    check("arst_dp2", 64'(dout_dp2), 64'd0);
    check("arst_chn", 64'(dout_chn), 64'd0);
    idle(1);
    rst = 1'b0;
    dv_seen = 0;
    beats(SIZE, 8'd0);
    idle(2);
    check("arst_quiet", 64'(dv_seen), 64'd0);
    dv_seen = 0;
    beats(SIZE, 8'd0);
    idle(2);
    check("arst_reprime", 64'(dv_seen), 64'(SIZE));

    // Random traffic with occasional sync and bypass changes.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) bypass = ~bypass;
      step(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 9)), rnd(), rnd(),
           ($urandom_range(0, 99) == 0));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
